// File: rtl/i_cache_sa.sv
// i_cache_sa: set-associative read-only instruction cache with a multi-word block-fill FSM.
// Define ICACHE_CRITICAL_WORD_EN to fill from the requested word first and forward it on arrival.
module i_cache_sa #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SETS        = 64,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state;
    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  ptr      [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS][BLOCK_WORDS];

    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [WAY_W-1:0]  victim;
    logic [OFF_W-1:0]  word_cnt;
    logic [OFF_W-1:0]  fill_cnt;
    logic [OFF_W-1:0]  next_word;
    logic [OFF_W-1:0]  start_off;
    logic              flush_pend;
`ifdef ICACHE_CRITICAL_WORD_EN
    logic [OFF_W-1:0]  lat_off;
`endif

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_addr_lsb;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  vic_way;
    logic              vic_found;
    logic [WAY_W-1:0]  ptr_next;

    assign req_off         = req_addr[OFF_W:1];
    assign req_idx         = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag         = req_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign unused_addr_lsb = req_addr[0];
    assign next_word       = word_cnt + OFF_W'(1);
    assign ptr_next        = (ptr[lat_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr[lat_idx] + WAY_W'(1);

`ifdef ICACHE_CRITICAL_WORD_EN
    assign start_off = req_off;
`else
    assign start_off = '0;
`endif

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = ptr[req_idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid[req_idx][w]) begin
                vic_way   = WAY_W'(w);
                vic_found = 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_data  = '0;
        miss     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        rd_valid = 1'b1;
                        rd_data  = data_mem[req_idx][hit_way][req_off];
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            FILL: begin
                miss = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_EN
                if (mem_valid && (word_cnt == lat_off)) begin
                    rd_valid = 1'b1;
                    rd_data  = mem_data;
                end
`endif
            end
            default: miss = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            victim     <= '0;
            word_cnt   <= '0;
            fill_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
`ifdef ICACHE_CRITICAL_WORD_EN
            lat_off    <= '0;
`endif
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                ptr[s]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !hit) begin
                        lat_tag                 <= req_tag;
                        lat_idx                 <= req_idx;
                        victim                  <= vic_way;
                        valid[req_idx][vic_way] <= 1'b0;
                        word_cnt                <= start_off;
                        fill_cnt                <= '0;
                        mem_req                 <= 1'b1;
                        mem_addr                <= {req_tag, req_idx, start_off, 1'b0};
                        state                   <= FILL;
`ifdef ICACHE_CRITICAL_WORD_EN
                        lat_off                 <= req_off;
`endif
                    end
                    // Flush lands after the lookup above, so a same-cycle hit still sees old state.
                    if (flush) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            ptr[s]   <= '0;
                        end
                    end
                end
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_valid) begin
                        word_cnt <= next_word;
                        fill_cnt <= fill_cnt + OFF_W'(1);
                        if (fill_cnt == OFF_W'(BLOCK_WORDS - 1)) begin
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                            state    <= DONE;
                        end else begin
                            mem_addr <= {lat_tag, lat_idx, next_word, 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            ptr[s]   <= '0;
                        end
                    end else begin
                        valid[lat_idx][victim] <= 1'b1;
                        ptr[lat_idx]           <= ptr_next;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_valid)
            data_mem[lat_idx][victim][word_cnt] <= mem_data;
        if (state == DONE)
            tag_mem[lat_idx][victim] <= lat_tag;
    end

endmodule

// File: tb/tb_i_cache_sa.sv
// tb_i_cache_sa: directed scoreboard bench for i_cache_sa with a fixed-latency memory model.
// Follows ICACHE_CRITICAL_WORD_EN to pick the expected fill order and forwarded words.
module tb_i_cache_sa;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        flush;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data  = '0;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned lat_cnt  = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_addr_q[$];

    i_cache_sa #(
        .ADDR_W(16),
        .DATA_W(16),
        .SETS(64),
        .WAYS(2),
        .BLOCK_WORDS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .flush(flush),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .miss(miss),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_valid(mem_valid),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_fill(input logic [15:0] addr);
        logic [2:0] start;
        logic [2:0] off;
`ifdef ICACHE_CRITICAL_WORD_EN
        start = addr[3:1];
`else
        start = 3'd0;
`endif
        for (int unsigned i = 0; i < 8; i++) begin
            off = start + 3'(i);
            exp_addr_q.push_back({addr[15:4], off, 1'b0});
        end
    endfunction

    // Memory: answers a held mem_req two cycles later with a one-cycle mem_valid pulse.
    always @(negedge clk) begin
        if (mem_valid || !mem_req || rst) begin
            mem_valid = 1'b0;
            lat_cnt   = 0;
        end else if (lat_cnt == 1) begin
            mem_valid = 1'b1;
            mem_data  = mem_addr ^ 16'hA5A5;
            if (exp_addr_q.size() == 0)
                check("fill_unexpected", 32'(mem_req), 32'd0);
            else
                check("fill_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end else begin
            lat_cnt++;
        end
    end

    task automatic do_read(input logic [15:0] addr, input bit exp_miss, input int unsigned n_fills,
                           input int unsigned flush_at, input string tag);
        int unsigned cyc;
        for (int unsigned f = 0; f < n_fills; f++) begin
            push_fill(addr);
`ifdef ICACHE_CRITICAL_WORD_EN
            exp_q.push_back(addr ^ 16'hA5A5);
`endif
        end
        exp_q.push_back(addr ^ 16'hA5A5);
        @(negedge clk);
        req_addr  = addr;
        req_valid = 1'b1;
        #1;
        check({tag, "_first_miss"}, 32'(miss), 32'(exp_miss));
        if (!exp_miss) check({tag, "_no_mem_req"}, 32'(mem_req), 32'd0);
        cyc = 0;
        while (1) begin
            if (rd_valid) begin
                if (exp_q.size() == 0)
                    check({tag, "_extra_rd_valid"}, 32'(rd_valid), 32'd0);
                else
                    check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
                if (!miss) break;
            end
            if (cyc >= 400) break;
            @(negedge clk);
            cyc++;
            flush = (flush_at != 0) && (cyc == flush_at);
            #1;
        end
        flush = 1'b0;
        check({tag, "_in_time"}, 32'(cyc < 400), 32'd1);
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_fill_drained"}, 32'(exp_addr_q.size()), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        logic [15:0] fourth;
        int unsigned cyc;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_miss", 32'(miss), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, then a neighbouring word of the same block hits.
        do_read(16'h1812, 1'b1, 1, 0, "cold_1812");
        do_read(16'h1814, 1'b0, 0, 0, "hit_1814");

        // Set 1 fills both ways, then tag 2 evicts tag 6 via the round-robin pointer.
        do_read(16'h0412, 1'b1, 1, 0, "fill_0412");
        do_read(16'h0812, 1'b1, 1, 0, "evict_0812");
        do_read(16'h1812, 1'b1, 1, 0, "reread_1812");
        do_read(16'h0812, 1'b0, 0, 0, "hit_0812");

        // Flush in IDLE with a simultaneous lookup: that lookup still hits.
        exp_q.push_back(16'h1812 ^ 16'hA5A5);
        @(negedge clk);
        req_addr  = 16'h1812;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_lookup_rd_valid", 32'(rd_valid), 32'd1);
        check("flush_lookup_miss", 32'(miss), 32'd0);
        check("flush_lookup_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        do_read(16'h0812, 1'b1, 1, 0, "post_flush_0812");
        do_read(16'h1812, 1'b1, 1, 0, "post_flush_1812");

        // Flush mid-fill: line stays invalid, so the held request refills once more.
        do_read(16'h2A34, 1'b1, 2, 6, "midfill_flush_2A34");
        do_read(16'h0812, 1'b1, 1, 0, "midfill_flushed_0812");

        // Reset while the fourth fill word is being requested.
        push_fill(16'h3C56);
        fourth = exp_addr_q[3];
        @(negedge clk);
        req_addr  = 16'h3C56;
        req_valid = 1'b1;
        #1;
        cyc = 0;
        while (!(mem_req && (mem_addr == fourth)) && (cyc < 200)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst_fill_reached_word4", 32'(cyc < 200), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_fill_mem_req", 32'(mem_req), 32'd0);
        check("rst_fill_mem_addr", 32'(mem_addr), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_q.delete();
        do_read(16'h3C56, 1'b1, 1, 0, "after_rst_3C56");

        // Idle with no request: a resident address produces no output.
        @(negedge clk);
        req_addr  = 16'h3C56;
        req_valid = 1'b0;
        #1;
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        check("idle_miss", 32'(miss), 32'd0);

        pulse_flush();
        do_read(16'h181A, 1'b1, 1, 0, "crit_181A");
        do_read(16'h3C56, 1'b1, 1, 0, "flushed_3C56");
        do_read(16'h181A, 1'b0, 0, 0, "hit_181A");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/i_cache_sa.md
# i_cache_sa

Parametrised set-associative, read-only instruction cache with a multi-word block-fill state machine, replacing the fixed direct-mapped instruction cache in front of the fetch stage. On a hit it serves the fetch request combinationally. On a miss it selects a victim way and fills the block from unified memory one word at a time over a request/valid handshake. A single-cycle flush invalidates all lines.

## Interface
- ADDR_W, 16, byte address width; addresses are word-aligned and bit 0 is ignored
- DATA_W, 16, instruction word width
- SETS, 64, number of sets; must be a power of two
- WAYS, 2, associativity; allowed values are 1, 2 or 4
- BLOCK_WORDS, 8, words per block; must be a power of two and at least 2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  fetch request; the requester holds req_addr stable until rd_valid
- req_addr  in  ADDR_W  fetch address
- flush  in  1  invalidate all lines
- rd_valid  out  1  rd_data is valid for req_addr this cycle; this is the only accept signal
- rd_data  out  DATA_W  returned instruction
- miss  out  1  cache is not serving a hit: lookup missed, or FSM not in IDLE
- mem_req  out  1  word request to memory, held until mem_valid
- mem_addr  out  ADDR_W  word address requested
- mem_valid  in  1  mem_data carries the requested word; a one-cycle pulse
- mem_data  in  DATA_W  fill data

## Operation
- Address split: offset = req_addr[log2(BLOCK_WORDS):1]; index = next log2(SETS) bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, BLOCK_WORDS data words. Storage per set: a round-robin victim pointer.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - Lookup is combinational over all ways.
  - On a hit: rd_valid=1 and rd_data = the addressed word.
  - On a miss with req_valid=1: miss=1, latch the address, choose the victim, clear the victim's valid bit, set word_cnt = start word, go to FILL.
  - Victim choice: the lowest-numbered invalid way; if every way is valid, the way named by the set's pointer.
- FILL:
  - mem_req=1; mem_addr = {latched tag, index, word_cnt, 1'b0}.
  - On mem_valid: write mem_data into the victim at word_cnt and increment word_cnt (wraps modulo BLOCK_WORDS).
  - After BLOCK_WORDS words have been written, go to DONE.
- DONE:
  - Write the tag, set valid=1, advance the set's pointer (modulo WAYS), return to IDLE.
  - The held request then hits in IDLE.
- flush:
  - In IDLE: clears every valid bit and resets every pointer at the clock edge; a simultaneous lookup is still evaluated against the pre-flush state.
  - In FILL or DONE: the flush is latched. DONE then leaves the filled line invalid and applies the flush on the transition to IDLE.
- req_valid=0 in IDLE: no state change; rd_valid=0 and miss=0.

## Timing
- Reset values: rd_valid=0, rd_data=0, miss=0, mem_req=0, mem_addr=0. All valid bits cleared, pointers=0, FSM=IDLE, pending flush cleared.
- Reset mid-fill: mem_req drops asynchronously and the partial line stays invalid.
- Hit latency: 0 cycles, combinational from req_addr.
- Miss penalty, with memory latency L cycles per word: 1 (detect) + BLOCK_WORDS×(L+1) (fill) + 1 (DONE), then a hit in IDLE.
- mem_valid is ignored outside FILL.
- miss stays high from the detect cycle until the hit cycle.

## Configuration
- ICACHE_CRITICAL_WORD_EN undefined:
  - The fill starts at word 0 and proceeds in ascending order.
  - rd_valid rises only on the post-DONE hit.
- ICACHE_CRITICAL_WORD_EN defined:
  - The fill starts at the requested offset and wraps.
  - In the FILL cycle where mem_valid delivers the requested word: rd_valid=1 and rd_data=mem_data (forwarded), while miss stays 1.
  - The requester may then drop or change its request. The fill still completes, and a new request waits until IDLE.

## Test plan
Default parameters. The memory model returns mem_data = mem_addr ^ 16'hA5A5 two cycles after mem_req.

- Reset, then read 0x1812 -> miss; mem_addr sequence is 0x1810…0x181E; after DONE, rd_valid=1 with rd_data=0xBDB7.
- Read 0x1814 next -> same-cycle hit, rd_data=0xBDB1, miss=0, no mem_req.
- Reads 0x0412 then 0x0812 (same set 1, tags 1 and 2) -> 0x0412 fills the second way and 0x0812 evicts way 0 (tag 6); re-read 0x1812 -> miss.
- flush asserted in IDLE, then read 0x0412 -> miss. flush asserted mid-fill -> fill completes, then the next read of the same address misses again.
- rst asserted at the fourth fill word -> mem_req=0 immediately; after release, read of the same address -> full fill from the start.
- ICACHE_CRITICAL_WORD_EN defined, read 0x181A -> first mem_addr=0x181A; rd_valid=1 with rd_data=0xBDBF when that word arrives; mem_addr then wraps 0x181C, 0x181E, 0x1810, ….
